// File: rtl/cnn_fifo_pkg.sv
// Shared constants and elaboration helpers for the CNN inter-stage FIFO.
// Optional feature macro used by this block: CNN_FIFO_FWFT_EN (first-word-fall-through).
`ifndef CNN_FIFO_PKG_SV
`define CNN_FIFO_PKG_SV

// Threshold sanity check, usable in generate conditions.
`define CNN_FIFO_THRESH_OK(depth, af, ae) (((af) >= 0) && ((af) <= (depth)) && ((ae) >= 0) && ((ae) < (depth)))

package cnn_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_DEPTH      = 4096;
   localparam int DEF_ADDR_W     = 12;
   localparam int DEF_PTR_W      = DEF_ADDR_W + 1;
   localparam int DEF_CNT_W      = DEF_ADDR_W + 1;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

`endif

// File: rtl/cnn_sync_fifo_if.sv
// Bus bundle between a CNN stage (master) and the inter-stage FIFO (slave).
// Handshake: a write happens on an edge where w_en=1 and the FIFO is not full (or is full but a read is
// accepted the same edge); a read happens where r_en=1 and the FIFO is not empty. There is no backpressure
// wait: a rejected request is dropped and latched in overflow/underflow. clear flushes and wins over both.
interface cnn_sync_fifo_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 12
);
   logic                  clear;
   logic                  w_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_W:0]       count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clear, w_en, din, r_en,
      input  dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  clear, w_en, din, r_en,
      output dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/cnn_fifo_mem.sv
// Simple dual-port storage array; no reset on the words so it maps onto block RAM.
// CNN_FIFO_FWFT_EN selects an asynchronous read port instead of the registered one.
module cnn_fifo_mem #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4096,
   parameter int ADDR_W     = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef CNN_FIFO_FWFT_EN
   logic unused_rd_ctrl;
   assign unused_rd_ctrl = ^{rst, clr, re};
   assign rdata = mem[raddr];
`else
   // Only the output register is reset; a same-address write returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      rdata <= '0;
      else if (clr) rdata <= '0;
      else if (re)  rdata <= mem[raddr];
   end
`endif

endmodule

// File: rtl/cnn_sync_fifo.sv
// Single-clock FIFO between CNN pipeline stages: pointers, occupancy, thresholds and sticky error flags.
// Define CNN_FIFO_FWFT_EN for first-word-fall-through reads (latency 0, r_en acts as pop).
module cnn_sync_fifo
   import cnn_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int AF_THRESH  = DEPTH - 4,
   parameter int AE_THRESH  = 4
) (
   input  logic            clk,
   input  logic            reset,
   cnn_sync_fifo_if.slave  fifo
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
   localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);

   if (!`CNN_FIFO_THRESH_OK(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
      $error("cnn_sync_fifo: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
   end
   if (ADDR_W != clog2(DEPTH) || DEPTH < 4 || (1 << ADDR_W) != DEPTH) begin : g_bad_depth
      $error("cnn_sync_fifo: DEPTH must be a power of two >= 4 and ADDR_W == log2(DEPTH)");
   end

   logic [PTR_W-1:0] wptr, rptr, count;
   logic             rd_acc, wr_acc;
   logic             overflow_q, underflow_q;

   // Wrap bit in the MSB makes full/empty distinguishable from the difference alone.
   assign count  = wptr - rptr;
   assign rd_acc = fifo.r_en & ~fifo.clear & ~fifo.empty;
   assign wr_acc = fifo.w_en & ~fifo.clear & (~fifo.full | rd_acc);

   assign fifo.count        = count;
   assign fifo.full         = (count == DEPTH_C);
   assign fifo.empty        = (count == '0);
   assign fifo.almost_full  = (count >= AF_C);
   assign fifo.almost_empty = (count <= AE_C);
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr        <= '0;
         rptr        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (fifo.clear) begin
         wptr        <= '0;
         rptr        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
         if (fifo.w_en & ~wr_acc) overflow_q  <= 1'b1;
         if (fifo.r_en & ~rd_acc) underflow_q <= 1'b1;
      end
   end

`ifdef CNN_FIFO_FWFT_EN
   assign fifo.rd_valid = ~fifo.empty;
`else
   logic rd_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           rd_valid_q <= 1'b0;
      else if (fifo.clear) rd_valid_q <= 1'b0;
      else                 rd_valid_q <= rd_acc;
   end

   assign fifo.rd_valid = rd_valid_q;
`endif

   cnn_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .rst   (reset),
      .clr   (fifo.clear),
      .we    (wr_acc),
      .waddr (wptr[ADDR_W-1:0]),
      .wdata (fifo.din),
      .re    (rd_acc),
      .raddr (rptr[ADDR_W-1:0]),
      .rdata (fifo.dout)
   );

endmodule

// File: tb/tb_cnn_sync_fifo.sv
// Bench for cnn_sync_fifo (DEPTH=8): directed scenarios plus random traffic against a queue model.
module tb_cnn_sync_fifo;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int AF    = 6;
   localparam int AE    = 1;

   // clock / reset
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cnn_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

   cnn_sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_W     (AW),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fifo  (bus.slave)
   );

   // reference model
   logic [DW-1:0] exp_q[$];
   bit            m_ov, m_un, m_rv;
   logic [DW-1:0] m_dout;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ov   = 1'b0;
      m_un   = 1'b0;
      m_rv   = 1'b0;
      m_dout = '0;
   endtask

   task automatic model_step(input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
      bit rd_ok, wr_ok;
      if (clr) begin
         model_reset();
      end else begin
         rd_ok = r && (exp_q.size() > 0);
         wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
         m_rv  = rd_ok;
         if (rd_ok) m_dout = exp_q.pop_front();
         if (wr_ok) exp_q.push_back(d);
         if (w && !wr_ok) m_ov = 1'b1;
         if (r && !rd_ok) m_un = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = exp_q.size();
      check_val({tag, ".count"}, 32'(bus.count), 32'(n));
      check_val({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
      check_val({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
      check_val({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AF));
      check_val({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
      check_val({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ov));
      check_val({tag, ".underflow"}, 32'(bus.underflow), 32'(m_un));
`ifdef CNN_FIFO_FWFT_EN
      check_val({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(n > 0));
      if (n > 0) check_val({tag, ".dout"}, 32'(bus.dout), 32'(exp_q[0]));
`else
      check_val({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rv));
      check_val({tag, ".dout"}, 32'(bus.dout), 32'(m_dout));
`endif
   endtask

   // driver: called just after a falling edge, returns just after the next one
   task automatic cycle(input string tag, input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
      bus.w_en  = w;
      bus.r_en  = r;
      bus.din   = d;
      bus.clear = clr;
      @(posedge clk);
      model_step(w, r, d, clr);
      @(negedge clk);
      bus.w_en  = 1'b0;
      bus.r_en  = 1'b0;
      bus.clear = 1'b0;
      check_all(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.w_en  = 1'b0;
      bus.r_en  = 1'b0;
      bus.din   = '0;
      bus.clear = 1'b0;
      model_reset();
      #1 reset = 1'b1;
      #2 check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // fill / drain
      for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, 1'b0, DW'(i), 1'b0);
      for (int i = 0; i < DEPTH; i++)  cycle("drain", 1'b0, 1'b1, '0, 1'b0);

      // overflow, underflow, clear
      for (int i = 1; i <= DEPTH + 1; i++) cycle("ovf", 1'b1, 1'b0, DW'(16'h0100 + i), 1'b0);
      for (int i = 0; i < DEPTH; i++)      cycle("ovf_drain", 1'b0, 1'b1, '0, 1'b0);
      cycle("udf", 1'b0, 1'b1, '0, 1'b0);
      cycle("clear", 1'b1, 1'b1, 16'hdead, 1'b1);

      // full with simultaneous read + write
      for (int i = 1; i <= DEPTH; i++) cycle("full_fill", 1'b1, 1'b0, DW'(16'h0200 + i), 1'b0);
      cycle("full_rw", 1'b1, 1'b1, 16'h00aa, 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle("full_drain", 1'b0, 1'b1, '0, 1'b0);

      // wrap-around with interleaved pairs
      for (int i = 0; i < 20; i++) begin
         cycle("wrap_w", 1'b1, 1'b0, DW'(16'h0300 + i), 1'b0);
         cycle("wrap_r", 1'b0, 1'b1, '0, 1'b0);
      end

      // async reset mid-stream
      for (int i = 1; i <= 5; i++) cycle("pre_rst", 1'b1, 1'b0, DW'(16'h0400 + i), 1'b0);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) cycle("post_rst_w", 1'b1, 1'b0, DW'(16'h0500 + i), 1'b0);
      for (int i = 0; i < 3; i++)  cycle("post_rst_r", 1'b0, 1'b1, '0, 1'b0);

      // random traffic, alternating write-heavy and read-heavy phases
      for (int i = 0; i < 600; i++) begin
         bit w, r, c;
         int wp;
         wp = ((i / 40) % 2 == 0) ? 75 : 30;
         w  = ($urandom_range(99) < wp);
         r  = ($urandom_range(99) < 100 - wp);
         c  = ($urandom_range(79) == 0);
         cycle("rand", w, r, DW'($urandom), c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
